fwd_hazard_ctrl: RTL

- Controller for the EX-stage ALU operand muxes (ALU_in1 and ALU_in2 source select).
- Keeps its own shadow copies of destination/control fields for the instructions in EX and MEM.
- Produces registered ForwardA, ForwardB and store-data forward selects for the instruction entering EX.
- Drives load-use stall, bubble insertion, branch flush and data-memory wait freeze for the 5-stage pipeline.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/fwd_sel.sv | 46 ++++
 rtl/fwd_hazard_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types and constants for the 5-stage pipeline forwarding
//             and hazard control logic.
//  Contents : REG_ADDR_W, forward-select encodings, EX shadow record type.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int FWD_W      = 2;

    // Operand mux select encoding; 2'b11 is reserved and never produced.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file / immediate
    localparam logic [1:0] FWD_WB  = 2'b01;  // Write_data from WB
    localparam logic [1:0] FWD_MEM = 2'b10;  // rd_data from MEM

    // Control fields tracked for the instruction occupying EX.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;   // destination register
        logic                  rw;   // writes rd
        logic                  mr;   // is a load
    } shadow_t;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel
//  Purpose  : Combinational forward-select for one source operand. Compares
//             the source register against the EX and MEM shadows.
//  Ports    : src/use_src   - source register and its use flag
//             ex_rd/ex_rw   - EX shadow destination and write enable
//             mem_rd/mem_rw - MEM shadow destination and write enable
//             sel           - FWD_MEM, FWD_WB or FWD_RF
//  Revision : 1.0  initial release
// ============================================================================
module fwd_sel #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_rw,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_rw,
    output logic [FWD_W-1:0]      sel
);
    import pipe_pkg::*;

    logic w_hit_ex;
    logic w_hit_mem;

    // x0 is hard-wired zero, so a producer targeting it never matches.
    assign w_hit_ex  = ex_rw  && (ex_rd  != '0) && (ex_rd  == src);
    assign w_hit_mem = mem_rw && (mem_rd != '0) && (mem_rd == src);

    // The EX producer is younger than the MEM producer, so it wins.
    always_comb begin
        sel = FWD_RF;
        if (use_src) begin
            if (w_hit_ex) begin
                sel = FWD_MEM;
            end else if (w_hit_mem) begin
                sel = FWD_WB;
            end
        end
    end

endmodule : fwd_sel
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Purpose  : EX-stage operand forwarding and pipeline hazard control.
//             Tracks EX/MEM destination shadows, registers ForwardA/B/S for
//             the instruction entering EX, and drives load-use stall, branch
//             flush and data-memory freeze controls.
//  Ports    : clk, rst                    - clock, sync active-high reset
//             id_*                        - decoded fields of the ID instr
//             ex_branch_taken, dmem_wait  - flush / freeze requests
//             ForwardA/B/S                - registered operand selects
//             pc_write, ifid_write,
//             idex_bubble, ifid_flush     - pipeline control
//  Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  id_alu_src,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_wait,
    output logic [FWD_W-1:0]      ForwardA,
    output logic [FWD_W-1:0]      ForwardB,
    output logic [FWD_W-1:0]      ForwardS,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  idex_bubble,
    output logic                  ifid_flush
);
    import pipe_pkg::*;

    shadow_t               r_ex;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_rw;
    logic [FWD_W-1:0]      r_fwd_a;
    logic [FWD_W-1:0]      r_fwd_b;
    logic [FWD_W-1:0]      r_fwd_s;

    logic [FWD_W-1:0]      w_sel_a;
    logic [FWD_W-1:0]      w_sel_b;
    logic [FWD_W-1:0]      w_sel_s;
    logic                  w_use_b;
    logic                  w_load_use;
    logic                  w_kill;

    // Operand B takes the immediate when alu_src is set; any non-RF select
    // would override it, so the rs2 use is masked for the ALU path only.
    assign w_use_b = id_use_rs2 && !id_alu_src;

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .FWD_W(FWD_W)) u_sel_a (
        .src(id_rs1), .use_src(id_use_rs1),
        .ex_rd(r_ex.rd), .ex_rw(r_ex.rw),
        .mem_rd(r_mem_rd), .mem_rw(r_mem_rw),
        .sel(w_sel_a)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .FWD_W(FWD_W)) u_sel_b (
        .src(id_rs2), .use_src(w_use_b),
        .ex_rd(r_ex.rd), .ex_rw(r_ex.rw),
        .mem_rd(r_mem_rd), .mem_rw(r_mem_rw),
        .sel(w_sel_b)
    );

    fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .FWD_W(FWD_W)) u_sel_s (
        .src(id_rs2), .use_src(id_use_rs2),
        .ex_rd(r_ex.rd), .ex_rw(r_ex.rw),
        .mem_rd(r_mem_rd), .mem_rw(r_mem_rw),
        .sel(w_sel_s)
    );

    // A use-gated EX hit shows up as FWD_MEM on the rs1 or rs2 selects; if
    // the EX producer is a load, its data is not available in time.
    assign w_load_use = id_valid && r_ex.mr &&
                        ((w_sel_a == FWD_MEM) || (w_sel_s == FWD_MEM));

    // Both a taken branch and a load-use stall turn the ID/EX slot into a
    // bubble; the branch additionally wins over the stall.
    assign w_kill = ex_branch_taken || w_load_use;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (dmem_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (w_load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex     <= '0;
            r_mem_rd <= '0;
            r_mem_rw <= 1'b0;
            r_fwd_a  <= FWD_RF;
            r_fwd_b  <= FWD_RF;
            r_fwd_s  <= FWD_RF;
        end else if (!dmem_wait) begin
            r_mem_rd <= r_ex.rd;
            r_mem_rw <= r_ex.rw;
            if (w_kill) begin
                r_ex    <= '0;
                r_fwd_a <= FWD_RF;
                r_fwd_b <= FWD_RF;
                r_fwd_s <= FWD_RF;
            end else begin
                r_ex.rd <= id_rd;
                r_ex.rw <= id_reg_write && id_valid;
                r_ex.mr <= id_mem_read && id_valid;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
                r_fwd_s <= w_sel_s;
            end
        end
    end

    assign ForwardA = r_fwd_a;
    assign ForwardB = r_fwd_b;
    assign ForwardS = r_fwd_s;

endmodule : fwd_hazard_ctrl
`default_nettype wire
